// File: rtl/rom_load_sequencer_if.sv
// HPS download bus plus ROM write port and load status for rom_load_sequencer.
interface rom_load_sequencer_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_we;
    logic        gfx_we;
    logic        prom_we;
    logic        game_reset;
    logic        dl_active;
    logic        dl_overflow;
    logic        dl_short;

    // HPS side: drives the download, observes everything else
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, wr_addr, wr_data, cpu_we, gfx_we, prom_we,
        input  game_reset, dl_active, dl_overflow, dl_short
    );

    // Sequencer side
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, wr_addr, wr_data, cpu_we, gfx_we, prom_we,
        output game_reset, dl_active, dl_overflow, dl_short
    );
endinterface

// File: rtl/rom_load_sequencer.sv
// Routes index-0 HPS downloads into the CPU, graphics and PROM regions,
// stretches each byte write with ioctl_wait and holds the game in reset
// until the load has settled.
module rom_load_sequencer #(
    parameter int unsigned CPU_SIZE        = 4096,
    parameter int unsigned GFX_SIZE        = 512,
    parameter int unsigned PROM_SIZE       = 256,
    parameter int unsigned WR_CYCLES       = 2,
    parameter int unsigned POST_RST_CYCLES = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_load_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    localparam int unsigned TOTAL      = CPU_SIZE + GFX_SIZE + PROM_SIZE;
    localparam logic [24:0] GFX_BASE   = 25'(CPU_SIZE);
    localparam logic [24:0] PROM_BASE  = 25'(CPU_SIZE + GFX_SIZE);
    localparam logic [24:0] ADDR_END   = 25'(TOTAL);
    localparam logic [13:0] GFX_OFS    = 14'(CPU_SIZE);
    localparam logic [13:0] PROM_OFS   = 14'(CPU_SIZE + GFX_SIZE);
    localparam logic [15:0] COUNT_FULL = 16'(TOTAL);
    localparam logic [3:0]  WR_LAST    = 4'(WR_CYCLES - 1);
    localparam logic [7:0]  HOLD_LOAD  = 8'(POST_RST_CYCLES);

    logic [2:0]  state_q, state_d;
    logic        wait_q, wait_d;
    logic [2:0]  we_q, we_d;            // {prom, gfx, cpu}
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        short_q, short_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        end_q, end_d;          // download fell while a write was in flight
    logic [7:0]  hold_q, hold_d;
    logic        game_reset_q, game_reset_d;
    logic        active_q, active_d;

    logic        idx0, dl0, wr0;
    logic [2:0]  sel;
    logic [13:0] local_addr;

    assign idx0 = (bus.ioctl_index == 8'd0);
    assign dl0  = bus.ioctl_download && idx0;
    assign wr0  = bus.ioctl_wr && idx0;

    // Region decode of the linear address; the full 25 bits take part in the compare
    always_comb begin
        sel        = '0;
        local_addr = '0;
        if (bus.ioctl_addr < GFX_BASE) begin
            sel        = 3'b001;
            local_addr = bus.ioctl_addr[13:0];
        end else if (bus.ioctl_addr < PROM_BASE) begin
            sel        = 3'b010;
            local_addr = bus.ioctl_addr[13:0] - GFX_OFS;
        end else if (bus.ioctl_addr < ADDR_END) begin
            sel        = 3'b100;
            local_addr = bus.ioctl_addr[13:0] - PROM_OFS;
        end
    end

    // Next-state logic; strobes default low so they last only the first WRITE cycle
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        we_d      = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        short_d   = short_q;
        wcnt_d    = wcnt_q;
        end_d     = end_q;
        hold_d    = hold_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (dl0) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    short_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (wr0) begin
                    state_d   = S_WRITE;
                    wr_addr_d = local_addr;
                    wr_data_d = bus.ioctl_dout;
                    we_d      = sel;
                    wait_d    = 1'b1;
                    wcnt_d    = WR_LAST;
                    end_d     = !dl0;
                    count_d   = (count_q == '1) ? count_q : count_q + 16'd1;
                    if (sel == 3'b000) ovf_d = 1'b1;
                end else if (!dl0) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                    if (count_q < COUNT_FULL) short_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr0) ovf_d = 1'b1;
                end_d = end_q || !dl0;
                if (wcnt_q == '0) begin
                    wait_d = 1'b0;
                    if (end_q || !dl0) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LOAD;
                        if (count_q < COUNT_FULL) short_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
                else              hold_d  = hold_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered status outputs follow the next state so they change with it
    always_comb begin
        game_reset_d = (state_d != S_RUN);
        active_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    end

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_q       <= 1'b0;
            we_q         <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            short_q      <= 1'b0;
            wcnt_q       <= '0;
            end_q        <= 1'b0;
            hold_q       <= '0;
            game_reset_q <= 1'b1;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            short_q      <= short_d;
            wcnt_q       <= wcnt_d;
            end_q        <= end_d;
            hold_q       <= hold_d;
            game_reset_q <= game_reset_d;
            active_q     <= active_d;
        end
    end

    assign bus.ioctl_wait  = wait_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.cpu_we      = we_q[0];
    assign bus.gfx_we      = we_q[1];
    assign bus.prom_we     = we_q[2];
    assign bus.game_reset  = game_reset_q;
    assign bus.dl_active   = active_q;
    assign bus.dl_overflow = ovf_q;
    assign bus.dl_short    = short_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: boundary-address table,
// randomized downloads against a region-arithmetic model, and hand-written
// corner sequences (dropped write, late download fall, reset mid-write).
module tb_rom_load_sequencer;
    localparam int unsigned CPU  = 4096;
    localparam int unsigned GFX  = 512;
    localparam int unsigned PROM = 256;
    localparam int unsigned TOT  = CPU + GFX + PROM;
    localparam int unsigned WRC  = 2;
    localparam int unsigned PRC  = 16;

    logic clk;
    logic rst;
    rom_load_sequencer_if bus();

    rom_load_sequencer #(
        .CPU_SIZE(CPU), .GFX_SIZE(GFX), .PROM_SIZE(PROM),
        .WR_CYCLES(WRC), .POST_RST_CYCLES(PRC)
    ) dut (
        .clk_sys(clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: bytes accepted and overflow seen in this download
    int unsigned m_count;
    bit          m_ovf;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [2:0]  we;   // {prom, gfx, cpu}
        logic [13:0] wa;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] strobes();
        return {bus.prom_we, bus.gfx_we, bus.cpu_we};
    endfunction

    // Which region a byte lands in, from the region sizes alone
    task automatic ref_decode(input int unsigned a, output logic [2:0] we, output logic [13:0] la);
        if (a < CPU) begin
            we = 3'b001; la = 14'(a);
        end else if (a < CPU + GFX) begin
            we = 3'b010; la = 14'(a - CPU);
        end else if (a < TOT) begin
            we = 3'b100; la = 14'(a - CPU - GFX);
        end else begin
            we = 3'b000; la = 14'd0;
        end
    endtask

    // One byte through the sequencer, checking strobe, stall length and latched data
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             input logic [2:0] exp_we, input logic [13:0] exp_wa);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr = 1'b0;
        check("first write cycle strobe", 32'(strobes()), 32'(exp_we));
        check("first write cycle wait", 32'(bus.ioctl_wait), 32'd1);
        check("first write cycle data", 32'(bus.wr_data), 32'(d));
        if (exp_we != 3'b000) check("first write cycle addr", 32'(bus.wr_addr), 32'(exp_wa));
        for (int i = 1; i < int'(WRC); i++) begin
            tick();
            check("later write cycle strobe", 32'(strobes()), 32'd0);
            check("later write cycle wait", 32'(bus.ioctl_wait), 32'd1);
            check("later write cycle data", 32'(bus.wr_data), 32'(d));
            if (exp_we != 3'b000) check("later write cycle addr", 32'(bus.wr_addr), 32'(exp_wa));
        end
        tick();
        check("wait released after write", 32'(bus.ioctl_wait), 32'd0);
        check("no strobe after write", 32'(strobes()), 32'd0);
        m_count++;
        if (exp_we == 3'b000) m_ovf = 1'b1;
    endtask

    task automatic send_model(input int unsigned a, input logic [7:0] d);
        logic [2:0]  we;
        logic [13:0] la;
        ref_decode(a, we, la);
        send_byte(25'(a), d, we, la);
    endtask

    task automatic start_download();
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
        check("dl_active on start", 32'(bus.dl_active), 32'd1);
        check("game_reset on start", 32'(bus.game_reset), 32'd1);
        check("flags cleared on start", 32'({bus.dl_overflow, bus.dl_short}), 32'd0);
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic wait_run(input int limit);
        int k = 0;
        while (bus.game_reset !== 1'b0 && k < limit) begin
            tick();
            k++;
        end
        check("RUN reached", 32'(bus.game_reset), 32'd0);
    endtask

    task automatic end_and_check_flags();
        bus.ioctl_download = 1'b0;
        wait_run(PRC + 10);
        check("dl_overflow vs model", 32'(bus.dl_overflow), 32'(m_ovf));
        check("dl_short vs model", 32'(bus.dl_short), 32'(m_count < TOT));
        check("dl_active after load", 32'(bus.dl_active), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;

        vecs[0]  = '{25'd0,        8'hA5, 3'b001, 14'd0};
        vecs[1]  = '{25'd4095,     8'h3C, 3'b001, 14'd4095};
        vecs[2]  = '{25'd4096,     8'h11, 3'b010, 14'd0};
        vecs[3]  = '{25'd4607,     8'h22, 3'b010, 14'd511};
        vecs[4]  = '{25'd4608,     8'h33, 3'b100, 14'd0};
        vecs[5]  = '{25'd4863,     8'h44, 3'b100, 14'd255};
        vecs[6]  = '{25'd4864,     8'h55, 3'b000, 14'd0};
        vecs[7]  = '{25'd5000,     8'h66, 3'b000, 14'd0};
        vecs[8]  = '{25'd0,        8'h77, 3'b001, 14'd0};
        vecs[9]  = '{25'h0004000,  8'h88, 3'b000, 14'd0};
        vecs[10] = '{25'h1FFFFFF,  8'h99, 3'b000, 14'd0};
        vecs[11] = '{25'd10,       8'h5A, 3'b001, 14'd10};

        rst                = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        m_count            = 0;
        m_ovf              = 1'b0;

        // Reset values
        #12;
        check("reset wait", 32'(bus.ioctl_wait), 32'd0);
        check("reset strobes", 32'(strobes()), 32'd0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset wr_data", 32'(bus.wr_data), 32'd0);
        check("reset game_reset", 32'(bus.game_reset), 32'd1);
        check("reset dl_active", 32'(bus.dl_active), 32'd0);
        check("reset flags", 32'({bus.dl_overflow, bus.dl_short}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle game_reset", 32'(bus.game_reset), 32'd1);

        // Full sequential load, then exact release latency
        start_download();
        for (int unsigned a = 0; a < TOT; a++) send_model(a, 8'(a) ^ 8'h5A);
        bus.ioctl_download = 1'b0;
        early = 1'b0;
        for (int k = 0; k <= int'(PRC); k++) begin
            tick();
            if (bus.game_reset !== 1'b1) early = 1'b1;
            if (k == 0) check("dl_active drops on hold", 32'(bus.dl_active), 32'd0);
        end
        check("game_reset held through hold", 32'(early), 32'd0);
        tick();
        check("game_reset low at latency", 32'(bus.game_reset), 32'd0);
        check("full load overflow", 32'(bus.dl_overflow), 32'd0);
        check("full load short", 32'(bus.dl_short), 32'd0);

        // Boundary table
        start_download();
        for (int i = 0; i < 12; i++) send_byte(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].wa);
        end_and_check_flags();

        // 100 random in-range bytes: short load, no overflow
        start_download();
        for (int i = 0; i < 100; i++) begin
            send_model($urandom_range(TOT - 1, 0), 8'($urandom));
            repeat ($urandom_range(2, 0)) tick();
        end
        end_and_check_flags();

        // Random addresses straddling the end of the map
        start_download();
        for (int i = 0; i < 200; i++) begin
            send_model($urandom_range(TOT + 300, 0), 8'($urandom));
            repeat ($urandom_range(1, 0)) tick();
        end
        end_and_check_flags();

        // ioctl_wr repeated while the previous byte is still being written
        start_download();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd20; bus.ioctl_dout = 8'h01;
        tick();
        check("drop: first strobe", 32'(strobes()), 32'b001);
        check("drop: first addr", 32'(bus.wr_addr), 32'd20);
        bus.ioctl_addr = 25'd21; bus.ioctl_dout = 8'h02;
        tick();
        bus.ioctl_wr = 1'b0;
        check("drop: no second strobe", 32'(strobes()), 32'd0);
        check("drop: addr kept", 32'(bus.wr_addr), 32'd20);
        check("drop: data kept", 32'(bus.wr_data), 32'h01);
        check("drop: overflow set", 32'(bus.dl_overflow), 32'd1);
        tick();
        check("drop: still no strobe", 32'(strobes()), 32'd0);
        check("drop: wait released", 32'(bus.ioctl_wait), 32'd0);
        m_count = 1;
        m_ovf   = 1'b1;
        send_model(30, 8'h30);
        end_and_check_flags();

        // Download falls during WRITE: the write completes, then HOLD
        start_download();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd4097; bus.ioctl_dout = 8'hC3;
        tick();
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        check("late fall: gfx strobe", 32'(strobes()), 32'b010);
        check("late fall: addr", 32'(bus.wr_addr), 32'd1);
        tick();
        check("late fall: wait held", 32'(bus.ioctl_wait), 32'd1);
        check("late fall: still active", 32'(bus.dl_active), 32'd1);
        tick();
        check("late fall: hold entered", 32'({bus.ioctl_wait, bus.dl_active, bus.game_reset}), 32'b001);
        m_count = 1;
        end_and_check_flags();

        // ioctl_wr and download fall in the same LOAD cycle
        start_download();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd4700; bus.ioctl_dout = 8'h3E;
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_wr = 1'b0;
        check("same cycle: prom strobe", 32'(strobes()), 32'b100);
        check("same cycle: addr", 32'(bus.wr_addr), 32'd92);
        check("same cycle: wait", 32'(bus.ioctl_wait), 32'd1);
        tick();
        tick();
        check("same cycle: hold entered", 32'({bus.ioctl_wait, bus.dl_active}), 32'd0);
        m_count = 1;
        end_and_check_flags();

        // Nonzero-index download while running is ignored
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.ioctl_wr   = 1'(i % 2);
            bus.ioctl_addr = 25'(i);
            tick();
            check("index1 ignored", 32'({strobes(), bus.ioctl_wait, bus.dl_active, bus.game_reset}), 32'd0);
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        tick();

        // Reset during the WRITE of address 10, then restart
        start_download();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd10; bus.ioctl_dout = 8'hE1;
        tick();
        bus.ioctl_wr = 1'b0;
        check("pre-reset cpu strobe", 32'(strobes()), 32'b001);
        #2;
        rst = 1'b1;
        #1;
        check("async reset strobes", 32'(strobes()), 32'd0);
        check("async reset wait", 32'(bus.ioctl_wait), 32'd0);
        check("async reset game_reset", 32'(bus.game_reset), 32'd1);
        check("async reset dl_active", 32'(bus.dl_active), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("restart after reset", 32'(bus.dl_active), 32'd1);
        m_count = 0;
        m_ovf   = 1'b0;
        send_model(10, 8'hE2);
        end_and_check_flags();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sequences HPS ROM downloads (index 0) into the Blockade core's three on-chip ROM regions: CPU program, character graphics, colour/timing PROM.
- Decodes the linear download address into per-region write strobes and local addresses, and stretches each write with ioctl_wait.
- Holds the game in reset during and shortly after the load, and reports load integrity.
- Sits between hps_io and the game block, replacing the direct dn_addr/dn_data/dn_wr path.

Parameters:
- CPU_SIZE, 4096, bytes in CPU program region (base 0).
- GFX_SIZE, 512, bytes in graphics region (base CPU_SIZE).
- PROM_SIZE, 256, bytes in PROM region (base CPU_SIZE+GFX_SIZE).
- WR_CYCLES, 2, clk_sys cycles each write occupies (1..15).
- POST_RST_CYCLES, 16, cycles game_reset stays high after download end (1..255).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  download index; only 0 is handled
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  linear byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  stall request to HPS
- wr_addr  out  14  region-local address
- wr_data  out  8  byte to write
- cpu_we  out  1  CPU ROM write strobe
- gfx_we  out  1  graphics ROM write strobe
- prom_we  out  1  PROM write strobe
- game_reset  out  1  active-high reset for the game
- dl_active  out  1  load in progress (LED)
- dl_overflow  out  1  sticky: byte addressed beyond all regions
- dl_short  out  1  sticky: download ended with fewer than CPU_SIZE+GFX_SIZE+PROM_SIZE bytes

Behaviour:
- Reset values: state IDLE, ioctl_wait=0, all *_we=0, wr_addr=0, wr_data=0, game_reset=1, dl_active=0, flags=0, byte count=0.
- States: IDLE, LOAD, WRITE, HOLD, RUN.
- IDLE:
  - game_reset=1.
  - ioctl_download=1 with index 0 -> LOAD; clear count and both flags.
- LOAD:
  - dl_active=1, game_reset=1.
  - ioctl_wr=1 -> latch address and data, decode region, go to WRITE.
  - ioctl_download=0 -> HOLD.
- Region decode:
  - a<CPU_SIZE -> cpu, wr_addr=a.
  - a<CPU_SIZE+GFX_SIZE -> gfx, wr_addr=a-CPU_SIZE.
  - a<total -> prom, wr_addr=a-CPU_SIZE-GFX_SIZE.
  - Otherwise: no strobe, dl_overflow<=1, byte still counted as accepted and wait still applied.
  - wr_addr uses low 14 bits; ioctl_addr bits above 14 participate in the compare.
- WRITE (WR_CYCLES cycles, entered the cycle after ioctl_wr):
  - The selected *_we is high for exactly the first cycle only; wr_addr/wr_data are stable for all WR_CYCLES.
  - ioctl_wait=1 for the whole state; it deasserts registered on exit.
  - The byte counter (16-bit, saturating) increments once on entry.
  - Exit -> LOAD.
  - If ioctl_download falls during WRITE, the write completes and then -> HOLD.
  - ioctl_wr during WRITE is a protocol violation: the byte is dropped and dl_overflow<=1.
- HOLD:
  - game_reset=1, dl_active=0; down-counter loaded with POST_RST_CYCLES.
  - On the entry cycle, dl_short<=1 if count<total.
  - Counter reaches 0 -> RUN.
- RUN:
  - game_reset=0.
  - A new index-0 download -> LOAD with flags cleared.
  - Downloads with a nonzero index are ignored in every state.
- Load-latency check: game_reset first goes 0 exactly POST_RST_CYCLES+1 cycles after the cycle ioctl_download is sampled low in LOAD.
- Async reset at any point returns to IDLE immediately. A write in progress is abandoned: strobes drop that cycle and ioctl_wait drops.
- Simultaneous ioctl_wr and download fall in LOAD: the write is taken (WRITE), and HOLD follows.

Test Plan:
- Full load of 4864 sequential bytes with WR_CYCLES=2: each byte gives one *_we pulse and 2 cycles of ioctl_wait. Address 4095 -> cpu_we, wr_addr=4095. Address 4096 -> gfx_we, wr_addr=0. Address 4608 -> prom_we, wr_addr=0. End state: flags 0, game_reset low 17 cycles after download falls.
- Download of 100 bytes then end -> dl_short=1, dl_overflow=0, RUN reached.
- Write to address 5000 -> no strobe, ioctl_wait still 2 cycles, dl_overflow=1; a following write to 0 -> cpu_we.
- ioctl_wr pulsed in the cycle after an accepted write -> second byte dropped, no extra strobe, dl_overflow=1.
- reset asserted during the WRITE cycle at address 10 -> same cycle: cpu_we=0, ioctl_wait=0, game_reset=1. After release: IDLE and a new download restarts.
- ioctl_index=1 download in RUN -> no strobes, game_reset stays 0, dl_active stays 0.
